// File: rtl/fp_normalize_if.sv
// Handshake bundle between the FP adder sum stage, the post-add normalizer and the rounding stage.
interface fp_normalize_if #(
   parameter int EXP_WIDTH = 5,
   parameter int SIG_WIDTH = 11,
   parameter int GRS_WIDTH = 3
);
   localparam int MW = SIG_WIDTH + GRS_WIDTH;
   localparam int SW = $clog2(MW) + 1;

   logic                 in_valid;
   logic                 in_ready;
   logic [MW:0]          in_mant;
   logic [EXP_WIDTH-1:0] in_exp;
   logic                 out_valid;
   logic                 out_ready;
   logic [MW-1:0]        out_mant;
   logic [EXP_WIDTH-1:0] out_exp;
   logic [SW-1:0]        out_shift;
   logic                 out_zero;
   logic                 out_denorm;
   logic                 out_ovf;

   modport master (
      output in_valid, in_mant, in_exp, out_ready,
      input  in_ready, out_valid, out_mant, out_exp, out_shift, out_zero, out_denorm, out_ovf
   );

   modport slave (
      input  in_valid, in_mant, in_exp, out_ready,
      output in_ready, out_valid, out_mant, out_exp, out_shift, out_zero, out_denorm, out_ovf
   );
endinterface

// File: rtl/fp_normalize.sv
// Post-add normalizer: undoes a carry with a single right shift, or left-shifts one bit per
// cycle until the hidden bit is set or the exponent bottoms out, then flags zero/denormal/overflow.
module fp_normalize #(
   parameter int EXP_WIDTH = 5,
   parameter int SIG_WIDTH = 11,
   parameter int GRS_WIDTH = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   fp_normalize_if.slave bus
);
   localparam int MW = SIG_WIDTH + GRS_WIDTH;
   localparam int SW = $clog2(MW) + 1;
   localparam logic [EXP_WIDTH-1:0] EXP_MAX = {EXP_WIDTH{1'b1}};
   localparam logic [EXP_WIDTH-1:0] EXP_ONE = EXP_WIDTH'(1);

   typedef enum logic [1:0] {IDLE = 2'd0, NORM = 2'd1, DONE = 2'd2} state_t;

   state_t               state, state_nxt;
   logic [MW:0]          m, m_nxt;
   logic [EXP_WIDTH-1:0] e, e_nxt;
   logic [SW-1:0]        cnt, cnt_nxt;
   logic                 valid_r, valid_nxt;
   logic [MW-1:0]        mant_r, mant_nxt;
   logic [EXP_WIDTH-1:0] exp_r, exp_nxt;
   logic [SW-1:0]        shift_r, shift_nxt;
   logic                 zero_r, zero_nxt;
   logic                 denorm_r, denorm_nxt;
   logic                 ovf_r, ovf_nxt;
   logic [EXP_WIDTH-1:0] exp_inc;

   assign exp_inc        = bus.in_exp + EXP_ONE;
   assign bus.in_ready   = (state == IDLE);
   assign bus.out_valid  = valid_r;
   assign bus.out_mant   = mant_r;
   assign bus.out_exp    = exp_r;
   assign bus.out_shift  = shift_r;
   assign bus.out_zero   = zero_r;
   assign bus.out_denorm = denorm_r;
   assign bus.out_ovf    = ovf_r;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state, working registers and result registers
   always_comb begin
      state_nxt  = state;
      m_nxt      = m;
      e_nxt      = e;
      cnt_nxt    = cnt;
      valid_nxt  = valid_r;
      mant_nxt   = mant_r;
      exp_nxt    = exp_r;
      shift_nxt  = shift_r;
      zero_nxt   = zero_r;
      denorm_nxt = denorm_r;
      ovf_nxt    = ovf_r;
      case (state)
         IDLE: begin
            if (bus.in_valid) begin
               zero_nxt   = 1'b0;
               denorm_nxt = 1'b0;
               ovf_nxt    = 1'b0;
               shift_nxt  = '0;
               cnt_nxt    = '0;
               if (bus.in_mant == '0) begin
                  zero_nxt  = 1'b1;
                  mant_nxt  = '0;
                  exp_nxt   = '0;
                  valid_nxt = 1'b1;
                  state_nxt = DONE;
               end else if (bus.in_mant[MW]) begin
                  // Fold the dropped bit into sticky so rounding still sees it
                  m_nxt     = {1'b0, bus.in_mant[MW:2], bus.in_mant[1] | bus.in_mant[0]};
                  e_nxt     = exp_inc;
                  valid_nxt = 1'b1;
                  state_nxt = DONE;
                  if (exp_inc == EXP_MAX) begin
                     ovf_nxt  = 1'b1;
                     exp_nxt  = EXP_MAX;
                     mant_nxt = '0;
                  end else begin
                     exp_nxt  = exp_inc;
                     mant_nxt = m_nxt[MW-1:0];
                  end
               end else begin
                  m_nxt     = bus.in_mant;
                  e_nxt     = (bus.in_exp == '0) ? EXP_ONE : bus.in_exp;
                  state_nxt = NORM;
               end
            end else begin
               state_nxt = IDLE;
            end
         end
         NORM: begin
            if (m[MW-1]) begin
               mant_nxt  = m[MW-1:0];
               exp_nxt   = e;
               shift_nxt = cnt;
               valid_nxt = 1'b1;
               state_nxt = DONE;
            end else if (e == EXP_ONE) begin
               mant_nxt   = m[MW-1:0];
               exp_nxt    = '0;
               shift_nxt  = cnt;
               denorm_nxt = 1'b1;
               valid_nxt  = 1'b1;
               state_nxt  = DONE;
            end else begin
               m_nxt   = {m[MW-1:0], 1'b0};
               e_nxt   = e - EXP_ONE;
               cnt_nxt = cnt + SW'(1);
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               valid_nxt = 1'b0;
               state_nxt = IDLE;
            end else begin
               state_nxt = DONE;
            end
         end
         default: begin
            valid_nxt = 1'b0;
            state_nxt = IDLE;
         end
      endcase
   end

   // Datapath and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m        <= '0;
         e        <= '0;
         cnt      <= '0;
         valid_r  <= 1'b0;
         mant_r   <= '0;
         exp_r    <= '0;
         shift_r  <= '0;
         zero_r   <= 1'b0;
         denorm_r <= 1'b0;
         ovf_r    <= 1'b0;
      end else begin
         m        <= m_nxt;
         e        <= e_nxt;
         cnt      <= cnt_nxt;
         valid_r  <= valid_nxt;
         mant_r   <= mant_nxt;
         exp_r    <= exp_nxt;
         shift_r  <= shift_nxt;
         zero_r   <= zero_nxt;
         denorm_r <= denorm_nxt;
         ovf_r    <= ovf_nxt;
      end
   end
endmodule

// File: tb/tb_fp_normalize.sv
// Directed-vector bench for fp_normalize with hand-computed results, latency, backpressure and reset abort.
module tb_fp_normalize;
   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   fp_normalize_if #(.EXP_WIDTH(5), .SIG_WIDTH(11), .GRS_WIDTH(3)) bus ();

   fp_normalize #(.EXP_WIDTH(5), .SIG_WIDTH(11), .GRS_WIDTH(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic run_vec(input string tag, input logic [14:0] mant, input logic [4:0] exp_in,
                          input int lat_exp, input logic [13:0] mant_exp, input logic [4:0] e_exp,
                          input logic [4:0] sh_exp, input logic z, input logic d, input logic o,
                          input bit hold);
      int   lat;
      logic rdy_hi;
      logic [13:0] mant_held;
      @(negedge clk);
      bus.out_ready = hold ? 1'b0 : 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_mant   = mant;
      bus.in_exp    = exp_in;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      lat    = 1;
      rdy_hi = 1'b0;
      while (!bus.out_valid && lat < 40) begin
         rdy_hi = rdy_hi | bus.in_ready;
         @(posedge clk);
         #1;
         lat++;
      end
      check({tag, "_lat"},    lat, lat_exp);
      check({tag, "_rdy_busy"}, {31'd0, rdy_hi | bus.in_ready}, 32'd0);
      check({tag, "_mant"},   {18'd0, bus.out_mant}, {18'd0, mant_exp});
      check({tag, "_exp"},    {27'd0, bus.out_exp}, {27'd0, e_exp});
      check({tag, "_shift"},  {27'd0, bus.out_shift}, {27'd0, sh_exp});
      check({tag, "_flags"},  {29'd0, bus.out_zero, bus.out_denorm, bus.out_ovf}, {29'd0, z, d, o});
      if (hold) begin
         mant_held = bus.out_mant;
         for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_valid"}, {31'd0, bus.out_valid}, 32'd1);
            check({tag, "_hold_rdy"},   {31'd0, bus.in_ready}, 32'd0);
            check({tag, "_hold_mant"},  {18'd0, bus.out_mant}, {18'd0, mant_held});
         end
         @(negedge clk);
         bus.out_ready = 1'b1;
      end
      @(posedge clk);
      #1;
      check({tag, "_valid_drop"}, {31'd0, bus.out_valid}, 32'd0);
      check({tag, "_rdy_back"},   {31'd0, bus.in_ready}, 32'd1);
   endtask

   initial begin
      logic seen_valid;
      n_checks      = 0;
      n_fail        = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_mant   = 15'h0000;
      bus.in_exp    = 5'd0;
      bus.out_ready = 1'b1;
      #23;
      check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_ready", {31'd0, bus.in_ready}, 32'd1);
      check("rst_outs",  {bus.out_mant, bus.out_exp, bus.out_shift, bus.out_zero, bus.out_denorm, bus.out_ovf}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      //       tag        mant      exp  lat mant_exp  e_exp shift z  d  o  hold
      run_vec("carry",   15'h4001, 5'd10, 1, 14'h2001, 5'd11, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_vec("normd",   15'h2000, 5'd15, 2, 14'h2000, 5'd15, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_vec("cancel",  15'h0100, 5'd20, 7, 14'h2000, 5'd15, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1);
      run_vec("underfl", 15'h0100, 5'd3,  4, 14'h0400, 5'd0,  5'd2, 1'b0, 1'b1, 1'b0, 1'b0);
      run_vec("zero",    15'h0000, 5'd12, 1, 14'h0000, 5'd0,  5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      run_vec("denin",   15'h0800, 5'd0,  2, 14'h0800, 5'd0,  5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      run_vec("maxsh",   15'h0001, 5'd20, 15, 14'h2000, 5'd7, 5'd13, 1'b0, 1'b0, 1'b0, 1'b0);
      run_vec("carry29", 15'h4000, 5'd29, 1, 14'h2000, 5'd30, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_vec("ovf",     15'h6000, 5'd30, 1, 14'h0000, 5'h1F, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);

      // Reset abort in the middle of the cancellation shift sequence
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_mant  = 15'h0100;
      bus.in_exp   = 5'd20;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      check("mid_busy", {31'd0, bus.in_ready}, 32'd0);
      rst_n = 1'b0;
      #1;
      check("abort_ready", {31'd0, bus.in_ready}, 32'd1);
      check("abort_valid", {31'd0, bus.out_valid}, 32'd0);
      check("abort_outs",  {bus.out_mant, bus.out_exp, bus.out_shift, bus.out_zero, bus.out_denorm, bus.out_ovf}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen_valid = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         seen_valid = seen_valid | bus.out_valid;
      end
      check("abort_no_valid", {31'd0, seen_valid}, 32'd0);
      run_vec("post_rst", 15'h0400, 5'd9, 5, 14'h2000, 5'd6, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end
endmodule

// File: doc/fp_normalize.md
Name: fp_normalize

Overview:
Post-add normalizer for the FP adder datapath. It is the inverse of the operand-alignment stage: alignment right-shifts the smaller significand by the exponent difference, and this block takes the raw sum significand (carry bit included) with the larger exponent, then shifts it back into normalized form. It left-shifts one bit per cycle under an FSM and adjusts the exponent. It flags zero, denormal and overflow results. Both sides use valid/ready handshakes, and the output feeds the rounding stage.

Parameters:
EXP_WIDTH, 5, exponent width (biased); all-ones = Inf/NaN.
SIG_WIDTH, 11, significand width including hidden bit.
GRS_WIDTH, 3, guard/round/sticky bits below the significand LSB.

Ports:
clk  input  1  clock.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  input operand valid.
in_ready  output  1  block can accept (high only in IDLE).
in_mant  input  SIG_WIDTH+GRS_WIDTH+1  raw sum; MSB = carry, next bit = hidden position, LSB = sticky.
in_exp  input  EXP_WIDTH  exponent of sum (larger operand exponent).
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts result.
out_mant  output  SIG_WIDTH+GRS_WIDTH  normalized significand incl. hidden bit and GRS.
out_exp  output  EXP_WIDTH  adjusted exponent.
out_shift  output  $clog2(SIG_WIDTH+GRS_WIDTH)+1  left-shift count applied.
out_zero  output  1  result is zero.
out_denorm  output  1  result is denormal (out_exp = 0).
out_ovf  output  1  exponent overflow (result = Inf).

Behaviour:
- Reset: FSM = IDLE. out_valid, out_mant, out_exp, out_shift, and all flags = 0. in_ready = 1 after reset.
- Reset asserted mid-operation: abort immediately, discard operand, no out_valid.
- Internal registers: m (SIG_WIDTH+GRS_WIDTH+1 bits), e (EXP_WIDTH), cnt.
- States: IDLE, NORM, DONE. in_ready = (state == IDLE), combinational from state.
- IDLE, handshake (in_valid & in_ready) at clock edge; evaluate in this priority:
  - in_mant == 0: out_zero = 1, out_mant = 0, out_exp = 0, go to DONE.
  - Carry bit set: m = in_mant >> 1 with new LSB = old LSB | old bit1 (sticky preserved), e = in_exp + 1.
    - If in_exp + 1 == all-ones: out_ovf = 1, out_exp = all-ones, out_mant = 0.
    - Go to DONE. out_shift = 0.
  - Otherwise: m = in_mant, e = max(in_exp, 1) (denormal input uses effective exponent 1), cnt = 0, go to NORM.
- NORM, evaluated once per cycle, in this priority:
  - Hidden bit of m set: go to DONE with out_exp = e.
  - e == 1: go to DONE with out_exp = 0, out_denorm = 1, no further shift.
  - Else: m <<= 1 (zero fill), e -= 1, cnt += 1.
- Zero cannot occur in NORM; it is screened in IDLE.
- Latency, counted from the accept edge:
  - Zero, carry and overflow cases: out_valid asserts 1 cycle after accept.
  - NORM case with k shifts: out_valid asserts k+2 cycles after accept.
  - Maximum k = SIG_WIDTH+GRS_WIDTH-1.
- DONE: out_valid = 1; out_mant = m[SIG_WIDTH+GRS_WIDTH-1:0], plus out_exp, out_shift and flags, held stable while out_ready = 0.
  - On out_valid & out_ready: out_valid drops next cycle and the FSM returns to IDLE.
  - No accept in the same cycle as a result handshake; minimum spacing between accepts is 2 cycles.
- Flags are mutually exclusive. All flags are cleared on every accept.
- in_valid while in_ready = 0 is ignored; the upstream holds data.

Test Plan:
- Carry normalize: in_mant = 15'h4001, in_exp = 10 -> out_mant = 14'h2001 (sticky kept), out_exp = 11, out_shift = 0, out_valid 1 cycle after accept.
- Already normalized: in_mant = 15'h2000, in_exp = 15 -> out_mant = 14'h2000, out_exp = 15, out_shift = 0, out_valid 2 cycles after accept.
- Cancellation: in_mant = 15'h0100, in_exp = 20 -> out_mant = 14'h2000, out_exp = 15, out_shift = 5, out_valid 7 cycles after accept, in_ready low throughout.
- Underflow to denormal: in_mant = 15'h0100, in_exp = 3 -> out_mant = 14'h0400, out_exp = 0, out_shift = 2, out_denorm = 1.
- Overflow: in_mant = 15'h6000, in_exp = 30 -> out_ovf = 1, out_exp = 5'h1F, out_mant = 0. Zero: in_mant = 0 -> out_zero = 1, out_exp = 0.
- Backpressure and reset:
  - Hold out_ready = 0 for 3 cycles in DONE -> outputs stable, in_ready = 0.
  - Pulse rst_n low during NORM of the cancellation case -> all outputs 0 immediately, in_ready = 1, no out_valid afterward.
